// File: rtl/proc_sequencer_pkg.sv
// Shared types and constants for the multi-cycle processor sequencer.
package proc_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEMWAIT,
        WB,
        DONE
    } seq_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 32'h0000_FFF0;
    localparam int          WAIT_W          = 3;

endpackage

// File: rtl/proc_sequencer_sat_counter.sv
// Up-counter that clears on demand and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments and an asynchronous reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC [-> MEMWAIT -> WB], start/done handshake,
// watchdog stop and saturating cycle/instruction counters.
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter int          LOAD_LAT = 1,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             reg_wr_en,
    input  logic             mem_wr_en,
    input  logic             load_inst,
    input  logic             ack,
    output logic             pc_init,
    output logic             pc_adv,
    output logic             ir_load,
    output logic             reg_wr_strobe,
    output logic             mem_wr_strobe,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count
);

    localparam logic [WAIT_W-1:0] WAIT_INIT =
        (LOAD_LAT > 0) ? WAIT_W'(LOAD_LAT - 1) : '0;

    seq_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;
    logic              active;
    logic              wd_fire;
    logic              run_start;

    assign active    = (state == FETCH) || (state == EXEC) || (state == MEMWAIT) || (state == WB);
    // The watchdog only watches a live run, so a frozen count in IDLE/DONE never re-triggers it.
    assign wd_fire   = active && (cycle_count == CNT_W'(TIMEOUT));
    assign run_start = (state == IDLE) && start;
    assign done      = (state == DONE);
    assign timeout   = timeout_q;

    // NOTE: every output gets a default before the case, so no latch can be inferred.
    always_comb begin
        pc_init       = 1'b0;
        pc_adv        = 1'b0;
        ir_load       = 1'b0;
        reg_wr_strobe = 1'b0;
        mem_wr_strobe = 1'b0;
        if (!wd_fire) begin
            case (state)
                IDLE:  pc_init = start & rst_n;
                FETCH: ir_load = 1'b1;
                EXEC: begin
                    if (!ack && !load_inst) begin
                        pc_adv        = 1'b1;
                        reg_wr_strobe = reg_wr_en;
                        mem_wr_strobe = mem_wr_en;
                    end
                end
                WB: begin
                    pc_adv        = 1'b1;
                    reg_wr_strobe = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (wd_fire) begin
            state     <= DONE;
            timeout_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        timeout_q <= 1'b0;
                    end
                end
                FETCH: state <= EXEC;
                EXEC: begin
                    if (ack) begin
                        state <= DONE;
                    end else if (load_inst) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= (LOAD_LAT > 0) ? MEMWAIT : WB;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEMWAIT: begin
                    if (wait_cnt == '0) begin
                        state <= WB;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                WB:   state <= FETCH;
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (active && !wd_fire),
        .q     (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_inst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (pc_adv),
        .q     (inst_count)
    );

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with LOAD_LAT=2 and a short watchdog (TIMEOUT=20).
module tb_proc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        reg_wr_en;
    logic        mem_wr_en;
    logic        load_inst;
    logic        ack;
    logic        pc_init;
    logic        pc_adv;
    logic        ir_load;
    logic        reg_wr_strobe;
    logic        mem_wr_strobe;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [15:0] inst_count;
    logic [6:0]  outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    proc_sequencer #(
        .CNT_W    (16),
        .LOAD_LAT (2),
        .TIMEOUT  (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .reg_wr_en     (reg_wr_en),
        .mem_wr_en     (mem_wr_en),
        .load_inst     (load_inst),
        .ack           (ack),
        .pc_init       (pc_init),
        .pc_adv        (pc_adv),
        .ir_load       (ir_load),
        .reg_wr_strobe (reg_wr_strobe),
        .mem_wr_strobe (mem_wr_strobe),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count),
        .inst_count    (inst_count)
    );

    // Bit order: pc_init pc_adv ir_load reg_wr_strobe mem_wr_strobe done timeout
    assign outs = {pc_init, pc_adv, ir_load, reg_wr_strobe, mem_wr_strobe, done, timeout};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1 after inputs are set: checks this cycle, then moves to the next one.
    task automatic cyc(input string tag, input logic [6:0] expected);
        #1;
        check(tag, 32'(outs), 32'(expected));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b1;
        reg_wr_en = 1'b0;
        mem_wr_en = 1'b0;
        load_inst = 1'b0;
        ack       = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with start=1: everything quiet
        for (int i = 0; i < 3; i++) begin
            check("reset_cycle_count", 32'(cycle_count), 32'd0);
            check("reset_inst_count", 32'(inst_count), 32'd0);
            cyc("reset_outs", 7'b0000000);
        end
        rst_n = 1'b1;
        cyc("pc_init_pulse", 7'b1000000);

        // Three ALU ops then a halt (reg_wr_en left high on the halt to show ack priority)
        reg_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("alu_fetch", 7'b0010000);
            cyc("alu_exec", 7'b0101000);
        end
        ack = 1'b1;
        cyc("ack_fetch", 7'b0010000);
        cyc("ack_exec", 7'b0000000);
        check("alu_cycle_count", 32'(cycle_count), 32'd8);
        check("alu_inst_count", 32'(inst_count), 32'd3);
        cyc("alu_done", 7'b0000010);
        cyc("alu_done_hold", 7'b0000010);
        start     = 1'b0;
        ack       = 1'b0;
        reg_wr_en = 1'b0;
        cyc("alu_done_release", 7'b0000010);
        cyc("alu_idle", 7'b0000000);
        check("idle_frozen_count", 32'(cycle_count), 32'd8);

        // Load with a two-cycle memory latency, then a store, then halt
        start = 1'b1;
        cyc("ld_pc_init", 7'b1000000);
        load_inst = 1'b1;
        reg_wr_en = 1'b1;
        cyc("ld_fetch", 7'b0010000);
        cyc("ld_exec_no_strobe", 7'b0000000);
        cyc("ld_memwait1", 7'b0000000);
        cyc("ld_memwait2", 7'b0000000);
        cyc("ld_wb", 7'b0101000);
        load_inst = 1'b0;
        reg_wr_en = 1'b0;
        mem_wr_en = 1'b1;
        cyc("st_fetch", 7'b0010000);
        cyc("st_exec", 7'b0100100);
        ack = 1'b1;
        cyc("st_ack_fetch", 7'b0010000);
        cyc("st_ack_exec", 7'b0000000);
        check("ld_st_cycle_count", 32'(cycle_count), 32'd9);
        check("ld_st_inst_count", 32'(inst_count), 32'd2);
        start     = 1'b0;
        ack       = 1'b0;
        mem_wr_en = 1'b0;
        cyc("ld_st_done", 7'b0000010);
        cyc("ld_st_idle", 7'b0000000);

        // Watchdog: endless no-op stream stopped at cycle_count == 20
        start = 1'b1;
        cyc("wd_pc_init", 7'b1000000);
        for (int j = 0; j < 20; j++) begin
            cyc("wd_run", (j % 2 == 0) ? 7'b0010000 : 7'b0100000);
        end
        cyc("wd_fire_no_strobe", 7'b0000000);
        check("wd_cycle_count", 32'(cycle_count), 32'd20);
        check("wd_inst_count", 32'(inst_count), 32'd10);
        cyc("wd_done", 7'b0000011);
        cyc("wd_done_hold1", 7'b0000011);
        cyc("wd_done_hold2", 7'b0000011);
        start = 1'b0;
        cyc("wd_done_release", 7'b0000011);
        cyc("wd_idle_sticky", 7'b0000001);
        start = 1'b1;
        cyc("wd_restart", 7'b1000001);
        check("restart_cycle_count", 32'(cycle_count), 32'd0);

        // Reset dropped in EXEC of a store: strobe must vanish at once
        mem_wr_en = 1'b1;
        cyc("rst_st_fetch", 7'b0010000);
        #1;
        check("rst_pre_strobe", 32'(outs), 32'b0100100);
        rst_n = 1'b0;
        #1;
        check("rst_abort_strobe", 32'(outs), 32'd0);
        check("rst_abort_count", 32'(cycle_count), 32'd0);
        @(posedge clk);
        #1;
        cyc("rst_hold1", 7'b0000000);
        cyc("rst_hold2", 7'b0000000);
        start = 1'b0;
        rst_n = 1'b1;
        cyc("post_rst_idle1", 7'b0000000);
        cyc("post_rst_idle2", 7'b0000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
